mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store memory stage with registered writeback.
// Loads and stores (op `EXE_LORE) are split into single-byte requests on a
// one-outstanding-byte memory port; other ops pass straight through in one cycle.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects misaligned LH/LHU/SH/LW/SW
// without touching memory and flags them on misalign_out for one cycle.

`ifndef OpBus
`define OpBus 2:0
`endif
`ifndef FunBus
`define FunBus 2:0
`endif
`ifndef RegBus
`define RegBus 4:0
`endif
`ifndef EXE_LORE
`define EXE_LORE 3'd5
`endif

module mem_stage (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [`OpBus]  op_in,
    input  logic [`FunBus] fun_in,
    input  logic [`RegBus] rd_in,
    input  logic [31:0]    res_in,
    input  logic [31:0]    imm_in,
    input  logic           rec_in,
    input  logic           reg_we_in,
    output logic [`RegBus] rd_out,
    output logic [31:0]    wdata_out,
    output logic           reg_we_out,
    output logic           rec_out,
    output logic           stall_out,
    output logic           mem_req_out,
    output logic           mem_we_out,
    output logic [31:0]    mem_addr_out,
    output logic [7:0]     mem_wdata_out,
    input  logic           mem_gnt_in,
    input  logic [7:0]     mem_rdata_in,
    output logic           misalign_out
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned BW   = 8;

    localparam logic [2:0] FUN_LB  = 3'b000;
    localparam logic [2:0] FUN_LH  = 3'b001;
    localparam logic [2:0] FUN_LW  = 3'b010;
    localparam logic [2:0] FUN_LBU = 3'b011;
    localparam logic [2:0] FUN_LHU = 3'b100;
    localparam logic [2:0] FUN_SB  = 3'b101;
    localparam logic [2:0] FUN_SH  = 3'b110;
    localparam logic [2:0] FUN_SW  = 3'b111;

    typedef enum logic {IDLE, XFER} state_e;

    // Index of the last byte of an access (size - 1).
    function automatic logic [1:0] last_idx(input logic [2:0] f);
        case (f)
            FUN_LB, FUN_LBU, FUN_SB: last_idx = 2'd0;
            FUN_LH, FUN_LHU, FUN_SH: last_idx = 2'd1;
            default:                 last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic is_store(input logic [2:0] f);
        is_store = (f == FUN_SB) || (f == FUN_SH) || (f == FUN_SW);
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] a);
        case (f)
            FUN_LH, FUN_LHU, FUN_SH: is_misaligned = a[0];
            FUN_LW, FUN_SW:          is_misaligned = (a != 2'b00);
            default:                 is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [XLEN-1:0]     asm_q, asm_d;
    logic [`FunBus]      fun_q, fun_d;
    logic [`RegBus]      dst_q, dst_d;

    logic [`RegBus]      rd_q, rd_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                reg_we_q, reg_we_d;
    logic                rec_q, rec_d;
    logic                mis_q, mis_d;

    logic                lore_in;
    logic                mis_in;
    logic                last_beat;
    logic [4:0]          byte_sh;
    logic [XLEN-1:0]     asm_full;
    logic [XLEN-1:0]     load_val;

    assign lore_in = rec_in && (op_in == `EXE_LORE);

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in = lore_in && is_misaligned(fun_in, res_in[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    // Byte lane of the current beat, and the word with the incoming read byte merged in.
    always_comb begin
        byte_sh   = {cnt_q, 3'b000};
        asm_full  = (asm_q & ~(XLEN'(8'hFF) << byte_sh)) | (XLEN'(mem_rdata_in) << byte_sh);
        last_beat = (state_q == XFER) && mem_gnt_in && (cnt_q == last_idx(fun_q));
        case (fun_q)
            FUN_LB:  load_val = XLEN'($signed(asm_full[BW-1:0]));
            FUN_LH:  load_val = XLEN'($signed(asm_full[2*BW-1:0]));
            FUN_LBU: load_val = XLEN'(asm_full[BW-1:0]);
            FUN_LHU: load_val = XLEN'(asm_full[2*BW-1:0]);
            FUN_LW:  load_val = asm_full;
            default: load_val = '0;
        endcase
    end

    // Memory port and stall; request and stall are forced low while reset is asserted.
    always_comb begin
        mem_req_out   = !rst_in && (state_q == XFER);
        mem_we_out    = mem_req_out && is_store(fun_q);
        mem_addr_out  = (state_q == XFER) ? (addr_q + XLEN'(cnt_q)) : '0;
        mem_wdata_out = (state_q == XFER) ? BW'(data_q >> byte_sh) : '0;
        stall_out     = !rst_in &&
                        (((state_q == IDLE) && lore_in && !mis_in) ||
                         ((state_q == XFER) && !last_beat));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        asm_d    = asm_q;
        fun_d    = fun_q;
        dst_d    = dst_q;
        rd_d     = '0;
        wdata_d  = '0;
        reg_we_d = 1'b0;
        rec_d    = 1'b0;
        mis_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rec_in) begin
                    if (lore_in) begin
                        if (mis_in) begin
                            rec_d = 1'b1;
                            mis_d = 1'b1;
                            rd_d  = rd_in;
                        end else begin
                            addr_d  = res_in;
                            data_d  = imm_in;
                            fun_d   = fun_in;
                            dst_d   = rd_in;
                            cnt_d   = 2'd0;
                            asm_d   = '0;
                            state_d = XFER;
                        end
                    end else begin
                        rd_d     = rd_in;
                        wdata_d  = res_in;
                        reg_we_d = reg_we_in;
                        rec_d    = 1'b1;
                    end
                end
            end
            XFER: begin
                if (mem_gnt_in) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                        rec_d   = 1'b1;
                        rd_d    = dst_q;
                        if (!is_store(fun_q)) begin
                            reg_we_d = 1'b1;
                            wdata_d  = load_val;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        asm_d = asm_full;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            data_q   <= '0;
            asm_q    <= '0;
            fun_q    <= '0;
            dst_q    <= '0;
            rd_q     <= '0;
            wdata_q  <= '0;
            reg_we_q <= 1'b0;
            rec_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            asm_q    <= asm_d;
            fun_q    <= fun_d;
            dst_q    <= dst_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
            reg_we_q <= reg_we_d;
            rec_q    <= rec_d;
            mis_q    <= mis_d;
        end
    end

    assign rd_out       = rd_q;
    assign wdata_out    = wdata_q;
    assign reg_we_out   = reg_we_q;
    assign rec_out      = rec_q;
    assign misalign_out = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage against a transaction-level model
// (byte-addressed memory, per-instruction beat list, expected writeback).

`ifndef OpBus
`define OpBus 2:0
`endif
`ifndef FunBus
`define FunBus 2:0
`endif
`ifndef RegBus
`define RegBus 4:0
`endif
`ifndef EXE_LORE
`define EXE_LORE 3'd5
`endif

module tb_mem_stage;

    logic           clk_in;
    logic           rst_in;
    logic [`OpBus]  op_in;
    logic [`FunBus] fun_in;
    logic [`RegBus] rd_in;
    logic [31:0]    res_in;
    logic [31:0]    imm_in;
    logic           rec_in;
    logic           reg_we_in;
    logic [`RegBus] rd_out;
    logic [31:0]    wdata_out;
    logic           reg_we_out;
    logic           rec_out;
    logic           stall_out;
    logic           mem_req_out;
    logic           mem_we_out;
    logic [31:0]    mem_addr_out;
    logic [7:0]     mem_wdata_out;
    logic           mem_gnt_in;
    logic [7:0]     mem_rdata_in;
    logic           misalign_out;

    mem_stage dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .op_in         (op_in),
        .fun_in        (fun_in),
        .rd_in         (rd_in),
        .res_in        (res_in),
        .imm_in        (imm_in),
        .rec_in        (rec_in),
        .reg_we_in     (reg_we_in),
        .rd_out        (rd_out),
        .wdata_out     (wdata_out),
        .reg_we_out    (reg_we_out),
        .rec_out       (rec_out),
        .stall_out     (stall_out),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_gnt_in    (mem_gnt_in),
        .mem_rdata_in  (mem_rdata_in),
        .misalign_out  (misalign_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    localparam logic [2:0] LORE = `EXE_LORE;

    int n_checks = 0;
    int n_pass   = 0;

    // Byte memory; unwritten locations read as a fixed hash of the address.
    logic [7:0] mem [logic [31:0]];

    // Expected registered outputs for the next sampling point.
    logic        exp_rec, exp_we, exp_mis, exp_full;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic int fsize(input logic [2:0] f);
        case (f)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd3:    return {24'd0, w[7:0]};
            3'd4:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic finish_sim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic check_regs();
        check("rec_out", 32'(rec_out), 32'(exp_rec));
        check("reg_we_out", 32'(reg_we_out), 32'(exp_we));
        check("misalign_out", 32'(misalign_out), 32'(exp_mis));
        if (exp_full) begin
            check("rd_out", 32'(rd_out), 32'(exp_rd));
            check("wdata_out", wdata_out, exp_wdata);
        end
    endtask

    // Present one instruction (held while stalled) until the model says it retires.
    // mode: 0 grant always high, 1 random grant, 2 grant low two cycles per byte.
    task automatic run_instr(input logic rec, input logic [2:0] op, input logic [2:0] fun,
                             input logic [4:0] rd, input logic [31:0] res, input logic [31:0] imm,
                             input logic we, input int mode);
        int          size, granted, lowrun, cyc;
        logic        lore, mis, store, g, last, done;
        logic [31:0] val, a;
        logic [7:0]  b;
        lore    = rec && (op == LORE);
        size    = fsize(fun);
        store   = (fun >= 3'd5);
        mis     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = lore && ((((fun == 3'd1) || (fun == 3'd4) || (fun == 3'd6)) && res[0]) ||
                       (((fun == 3'd2) || (fun == 3'd7)) && (res[1:0] != 2'b00)));
`endif
        granted = 0;
        lowrun  = 0;
        cyc     = 0;
        val     = '0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk_in);
            rst_in    = 1'b0;
            rec_in    = rec;
            op_in     = op;
            fun_in    = fun;
            rd_in     = rd;
            res_in    = res;
            imm_in    = imm;
            reg_we_in = we;
            case (mode)
                0:       g = 1'b1;
                1:       g = ($urandom_range(0, 2) != 0);
                default: g = (lowrun >= 2);
            endcase
            a = res + 32'(granted);
            mem_gnt_in   = g;
            mem_rdata_in = (lore && cyc > 0) ? rd_byte(a) : 8'($urandom);
            #1;
            check_regs();
            if (!lore || mis) begin
                check("req_idle", 32'(mem_req_out), 32'd0);
                check("stall_idle", 32'(stall_out), 32'd0);
                exp_rec  = rec;
                exp_mis  = mis;
                exp_full = 1'b1;
                exp_rd   = rec ? rd : 5'd0;
                exp_we   = rec && !mis && we;
                exp_wdata = (rec && !mis) ? res : 32'd0;
                done = 1'b1;
            end else if (cyc == 0) begin
                check("req_capture", 32'(mem_req_out), 32'd0);
                check("stall_capture", 32'(stall_out), 32'd1);
                exp_rec = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_full = 1'b0;
            end else begin
                check("req_xfer", 32'(mem_req_out), 32'd1);
                check("addr", mem_addr_out, a);
                check("we", 32'(mem_we_out), 32'(store));
                if (store) check("wbyte", 32'(mem_wdata_out), 32'(8'(imm >> (8 * granted))));
                last = g && (granted == size - 1);
                check("stall_xfer", 32'(stall_out), 32'(!last));
                exp_rec = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_full = 1'b0;
                if (g) begin
                    b = rd_byte(a);
                    if (store) mem[a] = 8'(imm >> (8 * granted));
                    else val[8*granted +: 8] = b;
                    granted++;
                    lowrun = 0;
                end else begin
                    lowrun++;
                end
                if (last) begin
                    exp_rec   = 1'b1;
                    exp_full  = 1'b1;
                    exp_rd    = rd;
                    exp_we    = !store;
                    exp_wdata = store ? 32'd0 : extend(fun, val);
                    done      = 1'b1;
                end
            end
            cyc++;
            if (cyc > 200) begin
                check("timeout", 32'd1, 32'd0);
                finish_sim();
            end
        end
    endtask

    initial begin
        // Reset with a load presented: request and stall must stay low.
        rst_in = 1'b1; rec_in = 1'b1; op_in = LORE; fun_in = 3'd2; rd_in = 5'd3;
        res_in = 32'h40; imm_in = '0; reg_we_in = 1'b1; mem_gnt_in = 1'b1; mem_rdata_in = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); #1;
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        exp_rec = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_full = 1'b1; exp_rd = '0; exp_wdata = '0;
        check_regs();

        // Directed: LW 0x100, pass-through, LB/LBU sign handling, SH with slow grants.
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h203] = 8'h80;
        run_instr(1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0, 0);
        run_instr(1'b1, LORE, 3'd2, 5'd7, 32'h100, 32'd0, 1'b1, 0);
        run_instr(1'b1, LORE, 3'd0, 5'd8, 32'h203, 32'd0, 1'b1, 0);
        run_instr(1'b1, LORE, 3'd3, 5'd9, 32'h203, 32'd0, 1'b1, 1);
        run_instr(1'b1, LORE, 3'd6, 5'd1, 32'h10, 32'hAABBCCDD, 1'b0, 2);
        run_instr(1'b1, 3'd1, 3'd0, 5'd4, 32'h1111, 32'd0, 1'b1, 0);
        run_instr(1'b1, LORE, 3'd7, 5'd2, 32'h20, 32'hCAFEF00D, 1'b0, 1);
        run_instr(1'b1, 3'd1, 3'd0, 5'd5, 32'h2222, 32'd0, 1'b1, 0);
        run_instr(1'b1, LORE, 3'd2, 5'd6, 32'h102, 32'd0, 1'b1, 0);
        run_instr(1'b1, LORE, 3'd2, 5'd10, 32'hFFFF_FFFE, 32'd0, 1'b1, 0);

        // Reset in the middle of a word load, after its first grant.
        @(negedge clk_in);
        rec_in = 1'b1; op_in = LORE; fun_in = 3'd2; rd_in = 5'd11; res_in = 32'h300;
        mem_gnt_in = 1'b1; #1;
        check_regs();
        check("mid_capture_stall", 32'(stall_out), 32'd1);
        @(negedge clk_in); #1;
        check("mid_first_req", 32'(mem_req_out), 32'd1);
        @(negedge clk_in);
        rst_in = 1'b1; #1;
        check("mid_rst_req", 32'(mem_req_out), 32'd0);
        check("mid_rst_stall", 32'(stall_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0; rec_in = 1'b0; #1;
        check("post_rst_req", 32'(mem_req_out), 32'd0);
        check("post_rst_stall", 32'(stall_out), 32'd0);
        check("post_rst_rec", 32'(rec_out), 32'd0);
        exp_rec = 1'b0; exp_we = 1'b0; exp_mis = 1'b0; exp_full = 1'b1; exp_rd = '0; exp_wdata = '0;
        run_instr(1'b1, LORE, 3'd2, 5'd11, 32'h300, 32'd0, 1'b1, 0);

        // Random mix of pass-through, bubbles, loads and stores.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [2:0]  op, fun;
            logic [31:0] addr;
            int          sel;
            r   = ($urandom_range(0, 9) != 0);
            op  = 3'($urandom);
            if ($urandom_range(0, 9) < 5) op = LORE;
            else if (op == LORE) op = op ^ 3'd1;
            fun = 3'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6)      addr = 32'($urandom_range(0, 63));
            else if (sel < 8) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else              addr = $urandom;
            run_instr(r, op, fun, 5'($urandom), addr, $urandom, 1'($urandom),
                      $urandom_range(0, 2));
        end
        run_instr(1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0, 0);

        finish_sim();
    end

endmodule
